// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch / prefetch queue slice.
package fetch_pkg;

   localparam int WORD_BYTES = 4;
   localparam int PC_W       = 8;
   localparam int WORD_W     = 8 * WORD_BYTES;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      CAPTURE
   } fetchState_e;

   // One prefetch queue entry: byte address of the first byte plus the assembled word.
   typedef struct packed {
      logic [PC_W-1:0]   wordPc;
      logic [WORD_W-1:0] word;
   } fetchEntry_t;

endpackage

// File: rtl/fetch_word_fifo.sv
// Show-ahead synchronous FIFO of {wordPc, word} entries; flush dominates push and pop.
module fetch_word_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  fetchEntry_t            pushEntry,
   output fetchEntry_t            headEntry,
   output logic                   headValid,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetchEntry_t   mem [DEPTH];
   logic [AW-1:0] wrPtr;
   logic [AW-1:0] rdPtr;
   logic          doPush;
   logic          doPop;

   assign doPush = push && !flush;
   assign doPop  = pop && headValid && !flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else if (flush) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         count <= count + CW'(doPush) - CW'(doPop);
      end
   end

   // NOTE: storage is deliberately not reset; the head is gated by headValid, so stale entries never escape.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushEntry;
   end

   assign headValid = (count != '0);
   assign headEntry = headValid ? mem[rdPtr] : '0;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Byte-serial instruction fetch from an 8-bit RAM port into a word prefetch queue.
// Optional FETCH_STALL_COUNT_EN adds a saturating count of busy cycles spent in ISSUE.
module fetch_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
   input  logic              clk,
   input  logic              reset,
   output logic [PC_W-1:0]   ramAddr,
   input  logic [7:0]        ramData,
   input  logic              ramBusy,
   output logic [WORD_W-1:0] instr,
   output logic [PC_W-1:0]   instrPc,
   output logic              instrValid,
   input  logic              instrReady,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirectPc
`ifdef FETCH_STALL_COUNT_EN
   ,
   output logic [15:0]       stallCount
`endif
);

   localparam int            CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetchState_e   state;
   fetchState_e   stateNext;
   logic [PC_W-1:0] pc;
   logic [1:0]    idx;
   logic [7:0]    lane0;
   logic [7:0]    lane1;
   logic [7:0]    lane2;
   logic [CW-1:0] count;
   logic [CW-1:0] countAfter;
   logic          push;
   logic          pop;
   fetchEntry_t   pushEntry;
   fetchEntry_t   headEntry;

   assign pop        = instrValid && instrReady;
   assign push       = (state == CAPTURE) && (idx == 2'd3) && !redirect;
   assign countAfter = count + CW'(push) - CW'(pop);

   // The last byte goes straight from the RAM into the pushed word.
   assign pushEntry.word   = {ramData, lane2, lane1, lane0};
   assign pushEntry.wordPc = pc - PC_W'(WORD_BYTES - 1);

   fetch_word_fifo #(
      .DEPTH(DEPTH)
   ) wordFifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect),
      .pushEntry (pushEntry),
      .headEntry (headEntry),
      .headValid (instrValid),
      .count     (count)
   );

   assign instr   = headEntry.word;
   assign instrPc = headEntry.wordPc;
   assign ramAddr = pc;

   // NOTE: stateNext gets its default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (count < FULL) stateNext = ISSUE;
         ISSUE:   if (!ramBusy) stateNext = CAPTURE;
         CAPTURE: stateNext = (countAfter < FULL) ? ISSUE : IDLE;
         default: stateNext = ISSUE;
      endcase
      if (redirect) stateNext = ISSUE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ISSUE;
         pc    <= RESET_PC;
         idx   <= '0;
         lane0 <= '0;
         lane1 <= '0;
         lane2 <= '0;
      end else begin
         state <= stateNext;
         if (redirect) begin
            pc  <= redirectPc & 8'hFC;
            idx <= '0;
         end else if (state == CAPTURE) begin
            pc  <= pc + 1'b1;
            idx <= idx + 1'b1;
            case (idx)
               2'd0:    lane0 <= ramData;
               2'd1:    lane1 <= ramData;
               2'd2:    lane2 <= ramData;
               default: ;
            endcase
         end
      end
   end

`ifdef FETCH_STALL_COUNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCount <= '0;
      end else if (state == ISSUE && ramBusy && stallCount != 16'hFFFF) begin
         stallCount <= stallCount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed and randomized bench for fetch_prefetch_queue against a word-stream reference model.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  ramAddr;
   logic [7:0]  ramData;
   logic        ramBusy;
   logic [31:0] instr;
   logic [7:0]  instrPc;
   logic        instrValid;
   logic        instrReady;
   logic        redirect;
   logic [7:0]  redirectPc;
`ifdef FETCH_STALL_COUNT_EN
   logic [15:0] stallCount;
`endif

   logic [7:0] mem [256];
   int         checkCount = 0;
   int         passCount  = 0;
   int         failCount  = 0;
   int         cycleNo    = 0;
   int         popCount   = 0;
   int         popsBefore;
   logic [7:0] expPc;

   always #5 clk = ~clk;

   fetch_prefetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (8'h00)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ramAddr    (ramAddr),
      .ramData    (ramData),
      .ramBusy    (ramBusy),
      .instr      (instr),
      .instrPc    (instrPc),
      .instrValid (instrValid),
      .instrReady (instrReady),
      .redirect   (redirect),
      .redirectPc (redirectPc)
`ifdef FETCH_STALL_COUNT_EN
      ,
      .stallCount (stallCount)
`endif
   );

   // RAM port B: an address presented while not busy returns its byte during the next cycle.
   always @(posedge clk) ramData <= ramBusy ? 8'hEE : mem[ramAddr];

   // Little-endian word starting at byte address a, with 8-bit address wrap.
   function automatic logic [31:0] wordAt(input logic [7:0] a);
      return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[a]};
   endfunction

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: every accepted word is compared with the next word of the expected stream.
   task automatic cycle();
      logic wasRedirect;
      wasRedirect = redirect;
      if (redirect) begin
         expPc = redirectPc & 8'hFC;
      end else if (instrValid && instrReady) begin
         check("popPc", 40'(instrPc), 40'(expPc));
         check("popWord", 40'(instr), 40'(wordAt(expPc)));
         expPc = expPc + 8'd4;
         popCount++;
      end
      @(posedge clk);
      #1;
      cycleNo++;
      if (wasRedirect) check("flushValid", 40'(instrValid), 40'(1'b0));
   endtask

   task automatic doReset();
      reset      = 1'b1;
      instrReady = 1'b0;
      ramBusy    = 1'b0;
      redirect   = 1'b0;
      @(posedge clk);
      #1;
      reset   = 1'b0;
      cycleNo = 1;
      expPc   = 8'h00;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      ramBusy    = 1'b0;
      instrReady = 1'b0;
      redirect   = 1'b0;
      redirectPc = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) mem[i] = 8'(8'h11 * (i + 1));

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rstRamAddr", 40'(ramAddr), 40'(8'h00));
      check("rstValid", 40'(instrValid), 40'(1'b0));
      check("rstInstr", 40'(instr), 40'(32'h0));
      check("rstInstrPc", 40'(instrPc), 40'(8'h00));
      reset   = 1'b0;
      cycleNo = 1;
      expPc   = 8'h00;

      // First word latency and content, decoder not ready
      repeat (7) cycle();
      check("validCycle8", 40'(instrValid), 40'(1'b0));
      cycle();
      check("validCycle9", 40'(instrValid), 40'(1'b1));
      check("firstWord", 40'(instr), 40'(32'h44332211));
      check("firstPc", 40'(instrPc), 40'(8'h00));

      // Queue fills, fetch parks at 0x10
      repeat (31) cycle();
      check("fullAddr", 40'(ramAddr), 40'(8'h10));
      check("fullHead", 40'(instr), 40'(32'h44332211));
      repeat (5) cycle();
      check("idleHold", 40'(ramAddr), 40'(8'h10));
      instrReady = 1'b1;
      cycle();
      instrReady = 1'b0;
      check("secondWord", 40'(instr), 40'(32'h88776655));
      check("secondPc", 40'(instrPc), 40'(8'h04));
      repeat (3) cycle();
      check("resumeAddr", 40'(ramAddr), 40'(8'h11));
      instrReady = 1'b1;
      repeat (40) cycle();

      // Three busy cycles on byte 1 of word 0
      doReset();
      repeat (2) cycle();
      ramBusy = 1'b1;
      repeat (3) cycle();
      ramBusy = 1'b0;
      repeat (5) cycle();
      check("busyValid11", 40'(instrValid), 40'(1'b0));
      cycle();
      check("busyValid12", 40'(instrValid), 40'(1'b1));
      check("busyWord", 40'(instr), 40'(32'h44332211));
`ifdef FETCH_STALL_COUNT_EN
      check("stallCount", 40'(stallCount), 40'(16'd3));
`endif

      // Redirect mid-word with two words queued
      repeat (10) cycle();
      check("twoQueued", 40'(instrValid), 40'(1'b1));
      redirect   = 1'b1;
      redirectPc = 8'h23;
      cycle();
      redirect = 1'b0;
      check("redirValid", 40'(instrValid), 40'(1'b0));
      repeat (7) cycle();
      check("redirValid8", 40'(instrValid), 40'(1'b0));
      cycle();
      check("redirValid9", 40'(instrValid), 40'(1'b1));
      check("redirPc", 40'(instrPc), 40'(8'h20));
      check("redirWord", 40'(instr), 40'(wordAt(8'h20)));
`ifdef FETCH_STALL_COUNT_EN
      check("stallKept", 40'(stallCount), 40'(16'd3));
`endif

      // Redirect to 0xFC with continuous consumption: wrap and 8-cycle throughput
      instrReady = 1'b1;
      redirect   = 1'b1;
      redirectPc = 8'hFC;
      cycle();
      redirect = 1'b0;
      repeat (8) cycle();
      check("wrapPcFC", 40'(instrPc), 40'(8'hFC));
      check("wrapWordFC", 40'(instr), 40'(wordAt(8'hFC)));
      repeat (7) cycle();
      check("gapValid", 40'(instrValid), 40'(1'b0));
      cycle();
      check("wrapPc00", 40'(instrPc), 40'(8'h00));
      check("wrapWord00", 40'(instr), 40'(wordAt(8'h00)));
      popsBefore = popCount;
      repeat (40) cycle();
      check("throughput", 40'(popCount - popsBefore), 40'(5));

      // Reset asserted during a CAPTURE cycle
      instrReady = 1'b0;
      cycle();
      check("preRstValid", 40'(instrValid), 40'(1'b1));
      reset = 1'b1;
      #1;
      check("midRstAddr", 40'(ramAddr), 40'(8'h00));
      check("midRstValid", 40'(instrValid), 40'(1'b0));
      check("midRstInstr", 40'(instr), 40'(32'h0));
      check("midRstPc", 40'(instrPc), 40'(8'h00));
`ifdef FETCH_STALL_COUNT_EN
      check("midRstStall", 40'(stallCount), 40'(16'd0));
`endif
      @(posedge clk);
      #1;
      reset   = 1'b0;
      cycleNo = 1;
      expPc   = 8'h00;
      repeat (7) cycle();
      check("restartValid8", 40'(instrValid), 40'(1'b0));
      cycle();
      check("restartValid9", 40'(instrValid), 40'(1'b1));
      check("restartPc", 40'(instrPc), 40'(8'h00));
      check("restartWord", 40'(instr), 40'(wordAt(8'h00)));

      // Randomized busy, ready and redirect traffic over fresh RAM contents
      reset = 1'b1;
      #1;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      @(posedge clk);
      #1;
      reset   = 1'b0;
      expPc   = 8'h00;
      popsBefore = popCount;
      for (int n = 0; n < 3000; n++) begin
         ramBusy    = ($urandom_range(3) == 0);
         instrReady = 1'($urandom_range(1));
         redirect   = ($urandom_range(49) == 0);
         redirectPc = 8'($urandom);
         cycle();
         redirect = 1'b0;
      end
      check("randomPops", 40'((popCount - popsBefore) > 100), 40'(1'b1));

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction fetch stage sitting directly upstream of the decoder and downstream of `SimpleRam` read port B. It walks a byte program counter and reads one byte per access from the 8-bit RAM, honouring its busy flag. It assembles 4 bytes into a little-endian 32-bit instruction word and buffers the words in a small prefetch FIFO. The decoder consumes that FIFO through a valid/ready handshake, and a redirect input flushes everything on taken branches.

## Interface

Parameters:
- `DEPTH`, default 4: prefetch FIFO depth in words; power of two, minimum 2.
- `RESET_PC`, default 8'h00: byte address fetched first after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `ramAddr`  out  8  byte address driven to RAM port B (`addrB`).
- `ramData`  in  8  RAM port B read data (`outB`).
- `ramBusy`  in  1  RAM port B busy (`busyB`).
- `instr`  out  32  head-of-queue instruction word.
- `instrPc`  out  8  byte address of `instr`'s first byte.
- `instrValid`  out  1  `instr`/`instrPc` are valid.
- `instrReady`  in  1  decoder accepts head word this cycle.
- `redirect`  in  1  one-cycle pulse: flush and restart at `redirectPc`.
- `redirectPc`  in  8  new fetch address; bits [1:0] ignored (forced 0).
- `stallCount`  out  16  present only with `FETCH_STALL_COUNT_EN`.

## Operation

- State machine:
  - IDLE: the queue is full (count == DEPTH) and byte index == 0; hold `ramAddr`. Go to ISSUE when count < DEPTH.
  - ISSUE: `ramAddr` = pc. If `ramBusy`=0 go to CAPTURE, else stay.
  - CAPTURE: latch `ramData` into byte lane [idx], then pc += 1 and idx += 1.
    - If idx was 3, push {b3,b2,b1,b0} with wordPc = pc-3 into the FIFO.
    - Next state is ISSUE if there is room for another word (count after this cycle's push/pop < DEPTH), else IDLE.
- A new word is started only when the FIFO has a free slot, so a push never meets a full FIFO.
- pc is 8-bit and wraps 8'hFF → 8'h00. A word straddling the wrap takes bytes FC..FF, and the next word starts at 00.
- FIFO is show-ahead: the head is on `instr`/`instrPc` while `instrValid`=1.
  - Pop occurs when `instrValid && instrReady`.
  - Push and pop in the same cycle leave count unchanged.
  - Pop with FIFO empty is ignored.
- Redirect has the highest priority:
  - FIFO is emptied (count=0) and the partial word is discarded (idx=0).
  - pc = {redirectPc[7:2],2'b00} and state = ISSUE.
  - Any pop or push in the same cycle is ignored.
- Reset values: `ramAddr`=RESET_PC, `instr`=0, `instrPc`=0, `instrValid`=0, pc=RESET_PC, idx=0, count=0, state=ISSUE, `stallCount`=0.

## Timing

- RAM contract: an address held in ISSUE with `ramBusy`=0 has valid `ramData` during the following cycle (CAPTURE), sampled at that cycle's closing edge.
- No busy stalls: 2 cycles per byte, 8 cycles per word.
  - The first word is valid in the 9th cycle after reset deasserts.
  - The first word is valid 9 cycles after the cycle `redirect` is sampled.
- Each cycle of `ramBusy`=1 in ISSUE adds exactly one cycle.
- `instrValid` rises the cycle after the push edge. It falls the cycle after the last word is popped or after redirect.
- Sustained throughput is 1 word per 8 cycles. Sustained consumption with `instrReady`=1 never reaches IDLE.

## Configuration

- `FETCH_STALL_COUNT_EN` defined:
  - Adds the `stallCount` output: a 16-bit counter incremented every cycle spent in ISSUE with `ramBusy`=1.
  - Saturates at 16'hFFFF, cleared only by reset; redirect does not clear it.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure

- `fetch_pkg` holds:
  - the state enum (IDLE, ISSUE, CAPTURE);
  - `WORD_BYTES` = 4;
  - `PC_W` = 8.
- Sub-module `fetch_word_fifo` (#DEPTH):
  - synchronous FIFO of {wordPc, word} (40 bits) with `push`, `pop`, `flush`, `count`, and show-ahead head;
  - flush dominates push and pop.
- The top level holds the FSM, pc, byte lanes and the stall counter.

## Test plan

- Preload RAM bytes 0..7 with 11,22,33,44,55,66,77,88; release reset, `instrReady`=0:
  - `instrValid` rises in cycle 9 with `instr`=32'h44332211, `instrPc`=0;
  - second word is 32'h88776655, `instrPc`=4.
- Hold `instrReady`=0 with DEPTH=4: after 4 words the state stays IDLE and `ramAddr` holds 8'h10. Then pulse `instrReady` once: fetch resumes at 8'h10.
- Assert `ramBusy` for 3 cycles during byte 1 of word 0:
  - the word arrives 3 cycles late with correct data;
  - `stallCount`=3 with the macro defined.
- Pulse `redirect` with `redirectPc`=8'h23 mid-word, FIFO holding 2 words:
  - `instrValid`=0 next cycle;
  - the next word has `instrPc`=8'h20 and data from bytes 20..23.
- Redirect to 8'hFC, then consume continuously: the words have `instrPc`=FC, then 00, with correct wrap.
- Assert `reset` mid-CAPTURE: all outputs return to their reset values immediately, and fetch restarts from RESET_PC.
